swap_ctrl: RTL and testbench

Multi-cycle sequencer for the SISC SWP instruction. Accepts a swap request from the control unit, drives register-file read addresses, pulses the swap-data latch enable, then issues two register-file writes through the swap-data output mux (rs gets old rt, rt gets old rs). Sits between the control unit and the register file / swap-data datapath. Holds `busy` so the control unit stalls instruction fetch until the swap retires.

---
 rtl/swap_ctrl_pkg.sv | 22 ++
 rtl/swap_ctrl.sv | 102 ++++++++++
 tb/tb_swap_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/swap_ctrl_pkg.sv
// Shared definitions for the SWP sequencer: state encoding, swap-data select
// codes and the acceptance rule used by the FSM.
package swap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WR_A = 3'd2,
        ST_WR_B = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Swap-data output mux codes, also used by the register-file write mux
    localparam logic SEL_RS = 1'b0;
    localparam logic SEL_RT = 1'b1;

    // A new swap may start only from IDLE or DONE, and never while frozen
    function automatic logic can_accept(input state_e st, input logic req, input logic frz);
        return ((st == ST_IDLE) || (st == ST_DONE)) && req && !frz;
    endfunction

endpackage

// File: rtl/swap_ctrl.sv
// SWP instruction sequencer: captures operands, drives register-file reads,
// pulses the swap-data latch, then issues the two crossed writes.
module swap_ctrl
    import swap_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap_req,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              hold,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              swap_en,
    output logic              sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State, operand and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, operand capture and retire counting; hold freezes everything
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (can_accept(state_q, swap_req, hold)) begin
                        state_d = ST_READ;
                        rs_d    = rs_addr;
                        rt_d    = rt_addr;
                    end
                end
                ST_READ: state_d = (rs_q == rt_q) ? ST_DONE : ST_WR_A;
                ST_WR_A: state_d = ST_WR_B;
                ST_WR_B: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Moore output decode from registered state and captured operands
    always_comb begin
        swap_en = 1'b0;
        sel     = SEL_RS;
        rf_we   = 1'b0;
        wr_addr = '0;
        done    = 1'b0;
        unique case (state_q)
            ST_READ: swap_en = 1'b1;
            ST_WR_A: begin
                sel     = SEL_RT;
                rf_we   = 1'b1;
                wr_addr = rs_q;
            end
            ST_WR_B: begin
                sel     = SEL_RS;
                rf_we   = 1'b1;
                wr_addr = rt_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr_a = rs_q;
    assign rd_addr_b = rt_q;
    assign busy      = (state_q != ST_IDLE);
    assign swap_cnt  = cnt_q;

endmodule

// File: tb/tb_swap_ctrl.sv
// Self-checking bench for swap_ctrl: directed vector table, multi-cycle corner
// sequences and random traffic against a schedule-based reference model.
module tb_swap_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          swap_req;
    logic [AW-1:0] rs_addr, rt_addr;
    logic          hold;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic          swap_en, sel, rf_we, busy, done;
    logic [CW-1:0] swap_cnt;

    swap_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .swap_req(swap_req), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .hold(hold), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .swap_en(swap_en), .sel(sel), .rf_we(rf_we),
        .wr_addr(wr_addr), .busy(busy), .done(done), .swap_cnt(swap_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register file and swap-data latch surrounding the sequencer
    logic [31:0] rf [16];
    logic [31:0] gold [16];
    logic [31:0] lat_a, lat_b;

    // Reference model: per-transaction schedule of expected output cycles
    typedef struct {
        bit       en;
        bit       we;
        bit       sel;
        bit [3:0] wa;
        bit       dn;
    } exp_t;

    exp_t     sched[$];
    int       mcnt;
    bit [3:0] m_rs, m_rt;

    typedef struct {
        bit       req, hld;
        bit [3:0] rs, rt;
        bit       busy, en, we, sel;
        bit [3:0] wa, ra, rb;
        bit       dn;
        bit [3:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic exp_t rec(bit en, bit we, bit s, bit [3:0] wa, bit dn);
        exp_t r;
        r.en = en; r.we = we; r.sel = s; r.wa = wa; r.dn = dn;
        return r;
    endfunction

    function automatic vec_t v(bit req, bit hld, bit [3:0] rs, bit [3:0] rt, bit bz, bit en,
                               bit we, bit s, bit [3:0] wa, bit [3:0] ra, bit [3:0] rb,
                               bit dn, bit [3:0] cnt);
        vec_t r;
        r.req = req; r.hld = hld; r.rs = rs; r.rt = rt; r.busy = bz; r.en = en;
        r.we = we; r.sel = s; r.wa = wa; r.ra = ra; r.rb = rb; r.dn = dn; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        mcnt = 0;
        m_rs = '0;
        m_rt = '0;
        for (int i = 0; i < 16; i++) gold[i] = rf[i];
    endtask

    // One clock: update datapath and model at the edge, then compare outputs
    task automatic step();
        logic          s_en, s_we, s_sel;
        logic [AW-1:0] s_wa, s_ra, s_rb;
        logic [31:0]   tmp;
        exp_t          e;
        int            bad;
        s_en = swap_en; s_we = rf_we; s_sel = sel;
        s_wa = wr_addr; s_ra = rd_addr_a; s_rb = rd_addr_b;
        @(posedge clk);
        if (s_en) begin
            lat_a = rf[s_ra];
            lat_b = rf[s_rb];
        end
        if (s_we) rf[s_wa] = s_sel ? lat_b : lat_a;
        if (!hold) begin
            if (swap_req && (sched.size() == 0 || sched[0].dn)) begin
                sched.delete();
                m_rs = rs_addr;
                m_rt = rt_addr;
                sched.push_back(rec(1, 0, 0, 0, 0));
                if (m_rs != m_rt) begin
                    sched.push_back(rec(0, 1, 1, m_rs, 0));
                    sched.push_back(rec(0, 1, 0, m_rt, 0));
                end
                sched.push_back(rec(0, 0, 0, 0, 1));
                tmp = gold[m_rs]; gold[m_rs] = gold[m_rt]; gold[m_rt] = tmp;
            end else if (sched.size() != 0) begin
                void'(sched.pop_front());
                if (sched.size() != 0 && sched[0].dn) mcnt = (mcnt + 1) % (1 << CW);
            end
        end
        #1;
        e = (sched.size() != 0) ? sched[0] : rec(0, 0, 0, 0, 0);
        chk("ctl", {busy, swap_en, rf_we, sel, wr_addr, done},
                   {sched.size() != 0, e.en, e.we, e.sel, e.wa, e.dn});
        chk("rdaddr", {rd_addr_a, rd_addr_b}, {m_rs, m_rt});
        chk("cnt", swap_cnt, mcnt);
        if (e.dn) begin
            bad = 0;
            for (int i = 0; i < 16; i++) if (rf[i] !== gold[i]) bad++;
            chk("rf_at_done", bad, 0);
        end
    endtask

    logic [31:0] r5_save, old_rt;
    int          start_cnt, guard;

    initial begin
        rst = 1'b1; swap_req = 1'b0; hold = 1'b0; rs_addr = '0; rt_addr = '0;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        rf[3] = 32'hAAAA0000;
        rf[7] = 32'h0000BBBB;
        lat_a = '0; lat_b = '0;
        model_reset();
        #12;
        chk("reset_out", {busy, swap_en, rf_we, sel, wr_addr, done, swap_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_after_reset", {busy, swap_en, rf_we, sel, wr_addr, done, swap_cnt}, 0);

        // req hld rs rt | busy en we sel wa ra rb done cnt
        tbl.push_back(v(1,0, 3, 7, 1,1,0,0, 0, 3, 7,0,0)); // 0 basic swap
        tbl.push_back(v(1,0, 3, 7, 1,0,1,1, 3, 3, 7,0,0));
        tbl.push_back(v(1,0, 3, 7, 1,0,1,0, 7, 3, 7,0,0));
        tbl.push_back(v(0,0, 3, 7, 1,0,0,0, 0, 3, 7,1,1));
        tbl.push_back(v(0,0, 3, 7, 0,0,0,0, 0, 3, 7,0,1));
        tbl.push_back(v(1,0, 5, 5, 1,1,0,0, 0, 5, 5,0,1)); // 5 same register
        tbl.push_back(v(0,0, 5, 5, 1,0,0,0, 0, 5, 5,1,2));
        tbl.push_back(v(0,0, 5, 5, 0,0,0,0, 0, 5, 5,0,2));
        tbl.push_back(v(1,0, 2, 9, 1,1,0,0, 0, 2, 9,0,2)); // 8 hold in WR_A
        tbl.push_back(v(0,0, 2, 9, 1,0,1,1, 2, 2, 9,0,2));
        tbl.push_back(v(0,1, 2, 9, 1,0,1,1, 2, 2, 9,0,2));
        tbl.push_back(v(0,1, 2, 9, 1,0,1,1, 2, 2, 9,0,2));
        tbl.push_back(v(0,1, 2, 9, 1,0,1,1, 2, 2, 9,0,2));
        tbl.push_back(v(0,0, 2, 9, 1,0,1,0, 9, 2, 9,0,2));
        tbl.push_back(v(0,0, 2, 9, 1,0,0,0, 0, 2, 9,1,3));
        tbl.push_back(v(0,0, 2, 9, 0,0,0,0, 0, 2, 9,0,3));
        tbl.push_back(v(1,0, 1, 4, 1,1,0,0, 0, 1, 4,0,3)); // 16 back-to-back
        tbl.push_back(v(1,0, 1, 4, 1,0,1,1, 1, 1, 4,0,3));
        tbl.push_back(v(1,0, 1, 4, 1,0,1,0, 4, 1, 4,0,3));
        tbl.push_back(v(1,0, 6, 8, 1,0,0,0, 0, 1, 4,1,4));
        tbl.push_back(v(1,0, 6, 8, 1,1,0,0, 0, 6, 8,0,4));
        tbl.push_back(v(0,0, 6, 8, 1,0,1,1, 6, 6, 8,0,4));
        tbl.push_back(v(0,0, 6, 8, 1,0,1,0, 8, 6, 8,0,4));
        tbl.push_back(v(0,0, 6, 8, 1,0,0,0, 0, 6, 8,1,5));
        tbl.push_back(v(0,0, 6, 8, 0,0,0,0, 0, 6, 8,0,5));
        tbl.push_back(v(1,1,10,11, 0,0,0,0, 0, 6, 8,0,5)); // 25 hold blocks accept
        tbl.push_back(v(1,0,10,11, 1,1,0,0, 0,10,11,0,5));
        tbl.push_back(v(0,0,10,11, 1,0,1,1,10,10,11,0,5));
        tbl.push_back(v(0,0,10,11, 1,0,1,0,11,10,11,0,5));
        tbl.push_back(v(0,0,10,11, 1,0,0,0, 0,10,11,1,6));
        tbl.push_back(v(1,1,12,12, 1,0,0,0, 0,10,11,1,6));
        tbl.push_back(v(1,0,12,12, 1,1,0,0, 0,12,12,0,6));
        tbl.push_back(v(0,0,12,12, 1,0,0,0, 0,12,12,1,7));
        tbl.push_back(v(0,0,12,12, 0,0,0,0, 0,12,12,0,7));

        r5_save = rf[5];
        for (int i = 0; i < tbl.size(); i++) begin
            swap_req = tbl[i].req; hold = tbl[i].hld;
            rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
            step();
            chk($sformatf("vec[%0d]", i),
                {busy, swap_en, rf_we, sel, wr_addr, rd_addr_a, rd_addr_b, done, swap_cnt},
                {tbl[i].busy, tbl[i].en, tbl[i].we, tbl[i].sel, tbl[i].wa, tbl[i].ra,
                 tbl[i].rb, tbl[i].dn, tbl[i].cnt});
            if (i == 4) begin
                chk("r3_swapped", rf[3], 32'h0000BBBB);
                chk("r7_swapped", rf[7], 32'hAAAA0000);
            end
            if (i == 7) chk("r5_unchanged", rf[5], r5_save);
        end

        // Sixteen swaps wrap the 4-bit counter back to its starting value
        start_cnt = mcnt;
        hold = 1'b0;
        for (int k = 0; k < 16; k++) begin
            swap_req = 1'b1; rs_addr = 4'(k); rt_addr = 4'(k + 3);
            guard = 0;
            do begin
                step();
                swap_req = 1'b0;
                guard++;
            end while (!(sched.size() != 0 && sched[0].dn) && guard < 10);
            chk("wrap_progress", guard < 10, 1);
        end
        step();
        chk("cnt_wrap", swap_cnt, start_cnt);

        // Reset during WR_B: first write kept, second lost, state cleared at once
        old_rt = rf[2];
        swap_req = 1'b1; rs_addr = 4'd1; rt_addr = 4'd2;
        step();
        swap_req = 1'b0;
        step();
        step();
        chk("in_wr_b", {rf_we, sel, wr_addr}, {1'b1, 1'b0, 4'd2});
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", {busy, rf_we, swap_en, done, wr_addr, swap_cnt}, 0);
        chk("rs_written", rf[1], old_rt);
        chk("rt_not_written", rf[2], old_rt);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            swap_req = ($urandom_range(0, 3) != 0);
            hold     = ($urandom_range(0, 4) == 0);
            rs_addr  = 4'($urandom_range(0, 15));
            rt_addr  = ($urandom_range(0, 5) == 0) ? rs_addr : 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
